id_ex_register: RTL and testbench
=================================

ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL have parameter WORD_W, default 32, width of PC and operand fields.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port freeze  input  1  hold all registered outputs this cycle.
REQ-005 SHALL have port flush  input  1  load a bubble (taken branch in EX).
REQ-006 SHALL have port id_valid  input  1  ID stage presents a real instruction.
REQ-007 SHALL have port id_pc  input  WORD_W  instruction PC+4.
REQ-008 SHALL have ports id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s  input  1 each  control bits.
REQ-009 SHALL have port id_exe_cmd  input  4  ALU command.
REQ-010 SHALL have ports id_val_rn, id_val_rm  input  WORD_W each  register-file operands.
REQ-011 SHALL have port id_imm  input  1  I bit for val2 generation.
REQ-012 SHALL have port id_shift_operand  input  12  {imm_rotate, imm_8} / shift field.
REQ-013 SHALL have port id_signed_imm_24  input  24  branch offset.
REQ-014 SHALL have ports id_dest, id_src1, id_src2  input  4 each  register indices.
REQ-015 SHALL have port id_sr  input  4  status flags {N,Z,C,V} sampled in ID.
REQ-016 SHALL have outputs ex_<field>, one per id_<field> above, same width, plus ex_valid  output  1.
REQ-017 SHALL have port bubble_cnt  output  16  inserted-bubble count (see Configuration).

Function
REQ-018 SHALL update only on rising clk; no combinational input-to-output path.
REQ-019 Per-cycle priority SHALL be: rst low > flush > freeze > normal load.
REQ-020 Normal load (rst high, flush 0, freeze 0): every ex_<field> <= id_<field>; ex_valid <= id_valid; latency exactly 1 cycle.
REQ-021 When id_valid=0 on a normal load, control outputs (wb_en, mem_r_en, mem_w_en, b, s) SHALL load 0; data fields load as presented.
REQ-022 Flush: ex_valid and all control outputs SHALL load 0; all data/index outputs SHALL load 0.
REQ-023 Freeze (flush 0): every output SHALL hold its previous value, including ex_valid.
REQ-024 Simultaneous flush and freeze: flush SHALL win; bubble inserted.
REQ-025 ex_shift_operand, ex_imm, ex_val_rm SHALL pass bit-exact, no transformation (val2 generation is downstream).
REQ-026 Back-to-back flushes SHALL each insert one bubble; no state beyond the register contents.

Reset
REQ-027 While rst=0 at a rising edge, all outputs including ex_valid and bubble_cnt SHALL become 0 on that edge, regardless of flush/freeze.
REQ-028 Reset asserted mid-freeze SHALL still clear all outputs; first edge with rst=1 performs a normal, flush, or freeze action per REQ-019 (freeze then holds zeros).

Configuration
REQ-029 Macro ID_EX_BUBBLE_CNT_EN SHALL gate the bubble counter.
REQ-030 With ID_EX_BUBBLE_CNT_EN defined: bubble_cnt SHALL increment by 1 on each edge where flush=1 or (normal load with id_valid=0); saturates at 16'hFFFF; holds during freeze without flush.
REQ-031 Without ID_EX_BUBBLE_CNT_EN: bubble_cnt SHALL be constant 0 and no counter flops synthesised; all other behaviour identical.

Verification
REQ-032 Reset: rst=0 one edge with all inputs 1s -> all outputs 0, ex_valid=0, bubble_cnt=0.
REQ-033 Pass-through: id_val_rm=32'hDEADBEEF, id_shift_operand=12'hA5C, id_imm=1, id_valid=1 -> next edge ex_val_rm=32'hDEADBEEF, ex_shift_operand=12'hA5C, ex_imm=1, ex_valid=1.
REQ-034 Freeze: load id_dest=4'h3, then freeze=1 for 3 cycles with id_dest=4'h7 -> ex_dest stays 4'h3 through all 3, becomes 4'h7 one edge after freeze drops.
REQ-035 Flush vs freeze: flush=1 and freeze=1 with id_wb_en=1, id_valid=1 -> ex_wb_en=0, ex_valid=0, ex_val_rn=0; bubble_cnt +1 when macro defined, 0 when not.
REQ-036 Saturation (macro defined): preload bubble_cnt to 16'hFFFE via 2 more flushes -> reaches 16'hFFFF, further flush leaves 16'hFFFF.

Source files
------------

// File: rtl/id_ex_register.sv
// ID/EX pipeline register.
// Captures the decoded instruction from ID for use by EX on the next cycle.
// Per-edge priority: reset (rst low) > flush (bubble) > freeze (hold) > load.
// Optional feature: define ID_EX_BUBBLE_CNT_EN to build a saturating 16-bit
// bubble counter on bubble_cnt. Without it, bubble_cnt is tied to zero.

module id_ex_register #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,

    input  logic              id_valid,
    input  logic [WORD_W-1:0] id_pc,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              id_mem_w_en,
    input  logic              id_b,
    input  logic              id_s,
    input  logic [3:0]        id_exe_cmd,
    input  logic [WORD_W-1:0] id_val_rn,
    input  logic [WORD_W-1:0] id_val_rm,
    input  logic              id_imm,
    input  logic [11:0]       id_shift_operand,
    input  logic [23:0]       id_signed_imm_24,
    input  logic [3:0]        id_dest,
    input  logic [3:0]        id_src1,
    input  logic [3:0]        id_src2,
    input  logic [3:0]        id_sr,

    output logic              ex_valid,
    output logic [WORD_W-1:0] ex_pc,
    output logic              ex_wb_en,
    output logic              ex_mem_r_en,
    output logic              ex_mem_w_en,
    output logic              ex_b,
    output logic              ex_s,
    output logic [3:0]        ex_exe_cmd,
    output logic [WORD_W-1:0] ex_val_rn,
    output logic [WORD_W-1:0] ex_val_rm,
    output logic              ex_imm,
    output logic [11:0]       ex_shift_operand,
    output logic [23:0]       ex_signed_imm_24,
    output logic [3:0]        ex_dest,
    output logic [3:0]        ex_src1,
    output logic [3:0]        ex_src2,
    output logic [3:0]        ex_sr,

    output logic [15:0]       bubble_cnt
);

    // A bubble and a reset both clear the stage, so they share one path.
    logic clear;
    // A normal load happens only when nothing of higher priority is active.
    logic load;

    // Decode the per-edge action from the control inputs.
    always_comb begin
        clear = !rst || flush;
        load  = !freeze;
    end

    // Control bits are qualified by id_valid so a non-instruction can never
    // write the register file or memory, even if ID leaves them set.
    always_ff @(posedge clk) begin
        if (clear) begin
            ex_valid    <= 1'b0;
            ex_wb_en    <= 1'b0;
            ex_mem_r_en <= 1'b0;
            ex_mem_w_en <= 1'b0;
            ex_b        <= 1'b0;
            ex_s        <= 1'b0;
        end else if (load) begin
            ex_valid    <= id_valid;
            ex_wb_en    <= id_wb_en    && id_valid;
            ex_mem_r_en <= id_mem_r_en && id_valid;
            ex_mem_w_en <= id_mem_w_en && id_valid;
            ex_b        <= id_b        && id_valid;
            ex_s        <= id_s        && id_valid;
        end
    end

    // Data and index fields pass through unmodified; val2 is built in EX.
    always_ff @(posedge clk) begin
        if (clear) begin
            ex_pc            <= '0;
            ex_exe_cmd       <= '0;
            ex_val_rn        <= '0;
            ex_val_rm        <= '0;
            ex_imm           <= 1'b0;
            ex_shift_operand <= '0;
            ex_signed_imm_24 <= '0;
            ex_dest          <= '0;
            ex_src1          <= '0;
            ex_src2          <= '0;
            ex_sr            <= '0;
        end else if (load) begin
            ex_pc            <= id_pc;
            ex_exe_cmd       <= id_exe_cmd;
            ex_val_rn        <= id_val_rn;
            ex_val_rm        <= id_val_rm;
            ex_imm           <= id_imm;
            ex_shift_operand <= id_shift_operand;
            ex_signed_imm_24 <= id_signed_imm_24;
            ex_dest          <= id_dest;
            ex_src1          <= id_src1;
            ex_src2          <= id_src2;
            ex_sr            <= id_sr;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q;
    logic [15:0] bubble_cnt_d;
    logic        bubble_evt;

    // A bubble enters EX on a flush, or on a normal load of an invalid slot.
    always_comb begin
        bubble_evt   = flush || (!freeze && !id_valid);
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_evt && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    // Counter register; reset overrides any pending bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    assign bubble_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// Directed self-checking bench for id_ex_register.
// Expectations for bubble_cnt follow ID_EX_BUBBLE_CNT_EN as defined for the build.

module tb_id_ex_register;

    localparam int unsigned WORD_W = 32;

`ifdef ID_EX_BUBBLE_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              freeze;
    logic              flush;
    logic              id_valid;
    logic [WORD_W-1:0] id_pc;
    logic              id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s;
    logic [3:0]        id_exe_cmd;
    logic [WORD_W-1:0] id_val_rn, id_val_rm;
    logic              id_imm;
    logic [11:0]       id_shift_operand;
    logic [23:0]       id_signed_imm_24;
    logic [3:0]        id_dest, id_src1, id_src2, id_sr;

    logic              ex_valid;
    logic [WORD_W-1:0] ex_pc;
    logic              ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s;
    logic [3:0]        ex_exe_cmd;
    logic [WORD_W-1:0] ex_val_rn, ex_val_rm;
    logic              ex_imm;
    logic [11:0]       ex_shift_operand;
    logic [23:0]       ex_signed_imm_24;
    logic [3:0]        ex_dest, ex_src1, ex_src2, ex_sr;
    logic [15:0]       bubble_cnt;

    int unsigned passed;
    int unsigned total;
    logic [15:0] exp_bubble;

    id_ex_register #(.WORD_W(WORD_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .freeze           (freeze),
        .flush            (flush),
        .id_valid         (id_valid),
        .id_pc            (id_pc),
        .id_wb_en         (id_wb_en),
        .id_mem_r_en      (id_mem_r_en),
        .id_mem_w_en      (id_mem_w_en),
        .id_b             (id_b),
        .id_s             (id_s),
        .id_exe_cmd       (id_exe_cmd),
        .id_val_rn        (id_val_rn),
        .id_val_rm        (id_val_rm),
        .id_imm           (id_imm),
        .id_shift_operand (id_shift_operand),
        .id_signed_imm_24 (id_signed_imm_24),
        .id_dest          (id_dest),
        .id_src1          (id_src1),
        .id_src2          (id_src2),
        .id_sr            (id_sr),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_wb_en         (ex_wb_en),
        .ex_mem_r_en      (ex_mem_r_en),
        .ex_mem_w_en      (ex_mem_w_en),
        .ex_b             (ex_b),
        .ex_s             (ex_s),
        .ex_exe_cmd       (ex_exe_cmd),
        .ex_val_rn        (ex_val_rn),
        .ex_val_rm        (ex_val_rm),
        .ex_imm           (ex_imm),
        .ex_shift_operand (ex_shift_operand),
        .ex_signed_imm_24 (ex_signed_imm_24),
        .ex_dest          (ex_dest),
        .ex_src1          (ex_src1),
        .ex_src2          (ex_src2),
        .ex_sr            (ex_sr),
        .bubble_cnt       (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model of the optional counter: one bubble inserted.
    task automatic bump();
        if (CntEn && exp_bubble != 16'hFFFF) exp_bubble = exp_bubble + 16'd1;
    endtask

    task automatic drive_all(input logic v);
        id_valid = v; id_pc = {WORD_W{v}};
        id_wb_en = v; id_mem_r_en = v; id_mem_w_en = v; id_b = v; id_s = v;
        id_exe_cmd = {4{v}}; id_val_rn = {WORD_W{v}}; id_val_rm = {WORD_W{v}};
        id_imm = v; id_shift_operand = {12{v}}; id_signed_imm_24 = {24{v}};
        id_dest = {4{v}}; id_src1 = {4{v}}; id_src2 = {4{v}}; id_sr = {4{v}};
    endtask

    task automatic test_reset();
        drive_all(1'b1);
        rst = 1'b0; flush = 1'b1; freeze = 1'b1;
        tick();
        exp_bubble = 16'h0;
        total++; if ({ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000",
                     {ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s});
        else passed++;
        total++; if ({ex_pc, ex_val_rn, ex_val_rm} !== '0)
            $display("FAIL reset_data: pc=%h rn=%h rm=%h want 0", ex_pc, ex_val_rn, ex_val_rm);
        else passed++;
        total++; if ({ex_exe_cmd, ex_imm, ex_shift_operand, ex_signed_imm_24, ex_dest, ex_src1,
                      ex_src2, ex_sr} !== '0)
            $display("FAIL reset_fields: cmd=%h sh=%h off=%h dest=%h want 0",
                     ex_exe_cmd, ex_shift_operand, ex_signed_imm_24, ex_dest);
        else passed++;
        total++; if (bubble_cnt !== 16'h0)
            $display("FAIL reset_bubble: got %h want 0000", bubble_cnt);
        else passed++;
        rst = 1'b1; flush = 1'b0; freeze = 1'b0;
    endtask

    task automatic test_pass_through();
        drive_all(1'b0);
        id_valid = 1'b1; id_val_rm = 32'hDEADBEEF; id_shift_operand = 12'hA5C; id_imm = 1'b1;
        tick();
        total++; if ({ex_val_rm, ex_shift_operand, ex_imm, ex_valid} !== {32'hDEADBEEF, 12'hA5C, 2'b11})
            $display("FAIL pass_through: rm=%h sh=%h imm=%b v=%b want deadbeef a5c 1 1",
                     ex_val_rm, ex_shift_operand, ex_imm, ex_valid);
        else passed++;
        total++; if (bubble_cnt !== exp_bubble)
            $display("FAIL pass_bubble: got %h want %h", bubble_cnt, exp_bubble);
        else passed++;
    endtask

    task automatic test_full_load();
        id_valid = 1'b1; id_pc = 32'h0000_1004;
        id_wb_en = 1'b1; id_mem_r_en = 1'b0; id_mem_w_en = 1'b1; id_b = 1'b0; id_s = 1'b1;
        id_exe_cmd = 4'h9; id_val_rn = 32'h1234_5678; id_val_rm = 32'h8765_4321;
        id_imm = 1'b0; id_shift_operand = 12'h3F1; id_signed_imm_24 = 24'hFFFFFE;
        id_dest = 4'hC; id_src1 = 4'h2; id_src2 = 4'hE; id_sr = 4'b1010;
        tick();
        total++; if ({ex_pc, ex_val_rn, ex_val_rm} !== {32'h0000_1004, 32'h1234_5678, 32'h8765_4321})
            $display("FAIL load_data: pc=%h rn=%h rm=%h want 00001004 12345678 87654321",
                     ex_pc, ex_val_rn, ex_val_rm);
        else passed++;
        total++; if ({ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s} !== 6'b110101)
            $display("FAIL load_ctrl: got %b want 110101",
                     {ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s});
        else passed++;
        total++; if ({ex_exe_cmd, ex_imm, ex_shift_operand, ex_signed_imm_24, ex_dest, ex_src1,
                      ex_src2, ex_sr} !== {4'h9, 1'b0, 12'h3F1, 24'hFFFFFE, 4'hC, 4'h2, 4'hE, 4'hA})
            $display("FAIL load_fields: cmd=%h imm=%b sh=%h off=%h d=%h s1=%h s2=%h sr=%h",
                     ex_exe_cmd, ex_imm, ex_shift_operand, ex_signed_imm_24, ex_dest, ex_src1,
                     ex_src2, ex_sr);
        else passed++;
    endtask

    task automatic test_invalid_load();
        drive_all(1'b1);
        id_valid = 1'b0; id_pc = 32'h0000_1234; id_val_rn = 32'h0BAD_F00D;
        tick();
        bump();
        total++; if ({ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s} !== 6'b0)
            $display("FAIL invalid_ctrl: got %b want 000000",
                     {ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s});
        else passed++;
        total++; if ({ex_pc, ex_val_rn, ex_dest} !== {32'h0000_1234, 32'h0BAD_F00D, 4'hF})
            $display("FAIL invalid_data: pc=%h rn=%h dest=%h want 00001234 0badf00d f",
                     ex_pc, ex_val_rn, ex_dest);
        else passed++;
        total++; if (bubble_cnt !== exp_bubble)
            $display("FAIL invalid_bubble: got %h want %h", bubble_cnt, exp_bubble);
        else passed++;
    endtask

    task automatic test_freeze();
        drive_all(1'b0);
        id_valid = 1'b1; id_dest = 4'h3;
        tick();
        total++; if (ex_dest !== 4'h3) $display("FAIL freeze_preload: got %h want 3", ex_dest);
        else passed++;
        freeze = 1'b1; id_dest = 4'h7;
        for (int i = 0; i < 3; i++) begin
            // Invalid slot while frozen must not count as a bubble.
            id_valid = (i == 2) ? 1'b0 : 1'b1;
            tick();
            total++; if ({ex_dest, ex_valid} !== {4'h3, 1'b1})
                $display("FAIL freeze_hold%0d: dest=%h v=%b want 3 1", i, ex_dest, ex_valid);
            else passed++;
        end
        total++; if (bubble_cnt !== exp_bubble)
            $display("FAIL freeze_bubble: got %h want %h", bubble_cnt, exp_bubble);
        else passed++;
        freeze = 1'b0; id_valid = 1'b1;
        tick();
        total++; if (ex_dest !== 4'h7) $display("FAIL freeze_release: got %h want 7", ex_dest);
        else passed++;
    endtask

    task automatic test_flush_freeze();
        id_valid = 1'b1; id_val_rn = 32'h5555_AAAA; id_wb_en = 1'b1;
        tick();
        flush = 1'b1; freeze = 1'b1;
        tick();
        bump();
        total++; if ({ex_wb_en, ex_valid, ex_val_rn} !== {2'b00, 32'h0})
            $display("FAIL flush_freeze: wb=%b v=%b rn=%h want 0 0 0", ex_wb_en, ex_valid, ex_val_rn);
        else passed++;
        total++; if (bubble_cnt !== exp_bubble)
            $display("FAIL flush_freeze_bubble: got %h want %h", bubble_cnt, exp_bubble);
        else passed++;
        flush = 1'b0; freeze = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive_all(1'b1);
        flush = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            bump();
            total++; if ({ex_valid, ex_wb_en, ex_pc, ex_dest} !== '0 || bubble_cnt !== exp_bubble)
                $display("FAIL b2b_flush%0d: v=%b pc=%h bubble=%h want 0 0 %h",
                         i, ex_valid, ex_pc, bubble_cnt, exp_bubble);
            else passed++;
        end
        flush = 1'b0;
        tick();
        total++; if ({ex_valid, ex_wb_en, ex_pc} !== {2'b11, 32'hFFFF_FFFF})
            $display("FAIL b2b_recover: v=%b wb=%b pc=%h want 1 1 ffffffff",
                     ex_valid, ex_wb_en, ex_pc);
        else passed++;
    endtask

    task automatic test_reset_mid_freeze();
        freeze = 1'b1; rst = 1'b0;
        tick();
        exp_bubble = 16'h0;
        total++; if ({ex_valid, ex_wb_en, ex_pc, ex_sr, bubble_cnt} !== '0)
            $display("FAIL rst_freeze: v=%b pc=%h sr=%h bubble=%h want 0",
                     ex_valid, ex_pc, ex_sr, bubble_cnt);
        else passed++;
        rst = 1'b1;
        tick();
        total++; if ({ex_valid, ex_pc} !== '0)
            $display("FAIL rst_freeze_hold: v=%b pc=%h want 0 0", ex_valid, ex_pc);
        else passed++;
        freeze = 1'b0; id_pc = 32'h0000_0040;
        tick();
        total++; if ({ex_valid, ex_pc} !== {1'b1, 32'h0000_0040})
            $display("FAIL rst_freeze_load: v=%b pc=%h want 1 00000040", ex_valid, ex_pc);
        else passed++;
    endtask

`ifdef ID_EX_BUBBLE_CNT_EN
    task automatic test_saturation();
        flush = 1'b1;
        while (exp_bubble != 16'hFFFE) begin
            tick();
            bump();
        end
        total++; if (bubble_cnt !== 16'hFFFE)
            $display("FAIL sat_preload: got %h want fffe", bubble_cnt);
        else passed++;
        tick();
        total++; if (bubble_cnt !== 16'hFFFF)
            $display("FAIL sat_reach: got %h want ffff", bubble_cnt);
        else passed++;
        tick();
        total++; if (bubble_cnt !== 16'hFFFF)
            $display("FAIL sat_hold: got %h want ffff", bubble_cnt);
        else passed++;
        flush = 1'b0;
    endtask
`endif

    initial begin
        passed = 0;
        total = 0;
        exp_bubble = 16'h0;
        rst = 1'b1; flush = 1'b0; freeze = 1'b0;
        drive_all(1'b0);
        #2;
        test_reset();
        test_pass_through();
        test_full_load();
        test_invalid_load();
        test_freeze();
        test_flush_freeze();
        test_back_to_back();
        test_reset_mid_freeze();
`ifdef ID_EX_BUBBLE_CNT_EN
        test_saturation();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
